// File: rtl/word_tokenizer_pkg.sv
// Shared token/ASCII/FSM definitions for the tokenizer and the begin/end nesting checker.
// Pure declarations: no latency, no flow control.
package word_tokenizer_pkg;

  localparam logic [1:0] TOK_OTHER = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  localparam logic [2:0] KW_BEGIN_LEN = 3'd5;
  localparam logic [2:0] KW_END_LEN   = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MB   = 2'd1,
    ME   = 2'd2,
    OTH  = 2'd3
  } tok_state_e;

  // Next expected keyword character once idx characters have matched.
  function automatic logic [7:0] kw_char(input logic is_begin, input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    if (is_begin) begin
      case (idx)
        3'd0: c = "b";
        3'd1: c = "e";
        3'd2: c = "g";
        3'd3: c = "i";
        3'd4: c = "n";
        default: c = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0: c = "e";
        3'd1: c = "n";
        3'd2: c = "d";
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/word_tokenizer_char_fold.sv
// Combinational ASCII case fold plus delimiter decode; WS_DELIM_EN adds tab/LF/CR as delimiters.
// Zero latency, no flow control.
module word_tokenizer_char_fold
  import word_tokenizer_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [7:0] fold_char,
  output logic       is_delim
);

`ifdef WS_DELIM_EN
  localparam bit WS_EN = 1'b1;
`else
  localparam bit WS_EN = 1'b0;
`endif

  logic ws_hit;

  always_comb begin
    fold_char = in_char;
    if (in_char >= "A" && in_char <= "Z") begin
      fold_char = in_char | 8'h20;
    end
    ws_hit   = (in_char == ASCII_TAB) || (in_char == ASCII_LF) || (in_char == ASCII_CR);
    is_delim = (in_char == ASCII_SPACE) || (ws_hit && WS_EN);
  end

endmodule

// File: rtl/word_tokenizer.sv
// Splits an ASCII stream into BEGIN/END/OTHER word tokens with saturating length (macro WS_DELIM_EN widens delimiters).
// Token appears one cycle after the closing delimiter/eos; downstream never stalls, so no backpressure.
module word_tokenizer
  import word_tokenizer_pkg::*;
#(
  parameter int MAX_LEN = 15,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     in,
  input  logic                           in_valid,
  input  logic                           eos,
  output logic                           tok_valid,
  output logic [1:0]                     tok_kind,
  output logic [$clog2(MAX_LEN+1)-1:0]   tok_len,
  output logic [CNT_W-1:0]               tok_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [7:0] c_fold;
  logic       is_delim;

  word_tokenizer_char_fold u_fold (
    .in_char   (in),
    .fold_char (c_fold),
    .is_delim  (is_delim)
  );

  tok_state_e       state_q, state_d, state_app;
  logic [2:0]       idx_q, idx_d, idx_app;
  logic [LEN_W-1:0] len_q, len_d, len_app;
  logic             tok_valid_q, tok_valid_d;
  logic [1:0]       tok_kind_q, tok_kind_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;

  logic word_char;
  logic close;

  assign word_char = in_valid && !is_delim;
  assign close     = (in_valid && is_delim) || eos;

  // Append step: a word character (if any) is folded into the match state first,
  // so eos in the same cycle closes the word including that character.
  always_comb begin
    state_app = state_q;
    idx_app   = idx_q;
    len_app   = len_q;
    if (word_char) begin
      if (state_q == IDLE) begin
        len_app = LEN_W'(1);
      end else if (len_q != LEN_W'(MAX_LEN)) begin
        len_app = len_q + LEN_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (c_fold == kw_char(1'b1, 3'd0)) begin
            state_app = MB;
            idx_app   = 3'd1;
          end else if (c_fold == kw_char(1'b0, 3'd0)) begin
            state_app = ME;
            idx_app   = 3'd1;
          end else begin
            state_app = OTH;
            idx_app   = 3'd0;
          end
        end
        MB: begin
          if (idx_q < KW_BEGIN_LEN && c_fold == kw_char(1'b1, idx_q)) begin
            idx_app = idx_q + 3'd1;
          end else begin
            state_app = OTH;
            idx_app   = 3'd0;
          end
        end
        ME: begin
          if (idx_q < KW_END_LEN && c_fold == kw_char(1'b0, idx_q)) begin
            idx_app = idx_q + 3'd1;
          end else begin
            state_app = OTH;
            idx_app   = 3'd0;
          end
        end
        default: begin
          state_app = OTH;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_app;
    idx_d       = idx_app;
    len_d       = len_app;
    tok_valid_d = 1'b0;
    tok_kind_d  = tok_kind_q;
    tok_len_d   = tok_len_q;
    tok_cnt_d   = tok_cnt_q;
    if (close) begin
      if (state_app != IDLE) begin
        tok_valid_d = 1'b1;
        tok_len_d   = len_app;
        tok_cnt_d   = tok_cnt_q + CNT_W'(1);
        if (state_app == MB && idx_app == KW_BEGIN_LEN) begin
          tok_kind_d = TOK_BEGIN;
        end else if (state_app == ME && idx_app == KW_END_LEN) begin
          tok_kind_d = TOK_END;
        end else begin
          tok_kind_d = TOK_OTHER;
        end
      end
      state_d = IDLE;
      idx_d   = 3'd0;
      len_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      len_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_kind_q  <= TOK_OTHER;
      tok_len_q   <= '0;
      tok_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tok_valid_q <= tok_valid_d;
      tok_kind_q  <= tok_kind_d;
      tok_len_q   <= tok_len_d;
      tok_cnt_q   <= tok_cnt_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_kind  = tok_kind_q;
  assign tok_len   = tok_len_q;
  assign tok_cnt   = tok_cnt_q;

endmodule

// File: tb/tb_word_tokenizer.sv
// Self-checking bench for word_tokenizer: word table plus hand-built eos/reset/wrap/whitespace sequences.
module tb_word_tokenizer;
  import word_tokenizer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_c = 8'h00;
  logic       in_valid = 1'b0;
  logic       eos = 1'b0;
  logic       tok_valid;
  logic [1:0] tok_kind;
  logic [3:0] tok_len;
  logic [7:0] tok_cnt;

  word_tokenizer #(.MAX_LEN(15), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_c),
    .in_valid  (in_valid),
    .eos       (eos),
    .tok_valid (tok_valid),
    .tok_kind  (tok_kind),
    .tok_len   (tok_len),
    .tok_cnt   (tok_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] kind;
    int         len;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  typedef struct {
    string      w;
    logic [1:0] kind;
    int         len;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[10];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic e);
    @(posedge clk);
    #1;
    in_c     = c;
    in_valid = v;
    eos      = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
  endtask

  // Called right after driving the closing cycle; the token is due one edge later.
  task automatic expect_tok(input logic [1:0] kind, input int len);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.kind = kind;
    e.len  = len;
    e.cnt  = exp_cnt;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    eos      = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    exp_cnt = 8'd0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && tok_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_token: kind %0d len %0d cnt %0d at cycle %0d, expected none",
                 tok_kind, tok_len, tok_cnt, cyc);
      end else begin
        e = sb.pop_front();
        check("tok_kind", 32'(tok_kind), 32'(e.kind));
        check("tok_len", 32'(tok_len), 32'(e.len));
        check("tok_cnt", 32'(tok_cnt), 32'(e.cnt));
        check("tok_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{"BeGiN", TOK_BEGIN, 5};
    vt[1] = '{"end", TOK_END, 3};
    vt[2] = '{"beginx", TOK_OTHER, 6};
    vt[3] = '{"ends", TOK_OTHER, 4};
    vt[4] = '{"en", TOK_OTHER, 2};
    vt[5] = '{"b", TOK_OTHER, 1};
    vt[6] = '{"END", TOK_END, 3};
    vt[7] = '{"begi", TOK_OTHER, 4};
    vt[8] = '{"xbegin", TOK_OTHER, 6};
    vt[9] = '{"xxxxxxxxxxxxxxxxxxxx", TOK_OTHER, 15};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_tok_valid", 32'(tok_valid), 32'd0);
    check("reset_tok_kind", 32'(tok_kind), 32'd0);
    check("reset_tok_len", 32'(tok_len), 32'd0);
    check("reset_tok_cnt", 32'(tok_cnt), 32'd0);

    // Delimiters and eos with no open word produce nothing.
    send("   ");
    step(8'h00, 1'b0, 1'b1);
    idle(3);
    check("no_word_cnt", 32'(tok_cnt), 32'd0);

    foreach (vt[i]) begin
      send(vt[i].w);
      step(" ", 1'b1, 1'b0);
      expect_tok(vt[i].kind, vt[i].len);
    end
    idle(3);

    send("end");
    step(8'h00, 1'b0, 1'b1);
    expect_tok(TOK_END, 3);
    send("en");
    step("d", 1'b1, 1'b1);
    expect_tok(TOK_END, 3);
    send("xy");
    step(" ", 1'b1, 1'b1);
    expect_tok(TOK_OTHER, 2);
    step("b", 1'b1, 1'b0);
    step("e", 1'b1, 1'b0);
    step("x", 1'b0, 1'b0);
    send("gin");
    step(" ", 1'b1, 1'b0);
    expect_tok(TOK_BEGIN, 5);
    idle(3);

`ifdef WS_DELIM_EN
    send("begin");
    step(8'h09, 1'b1, 1'b0);
    expect_tok(TOK_BEGIN, 5);
    send("end");
    step(8'h0A, 1'b1, 1'b0);
    expect_tok(TOK_END, 3);
`else
    send("begin\tend\n");
    idle(2);
    step(" ", 1'b1, 1'b0);
    expect_tok(TOK_OTHER, 10);
`endif
    idle(3);
    check("cnt_before_reset", 32'(tok_cnt), 32'(exp_cnt));

    // Partial word dropped by reset.
    send("beg");
    do_reset();
    send("in");
    step(" ", 1'b1, 1'b0);
    expect_tok(TOK_OTHER, 2);
    idle(3);
    check("cnt_after_reset", 32'(tok_cnt), 32'd1);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      step("a", 1'b1, 1'b0);
      step(" ", 1'b1, 1'b0);
      expect_tok(TOK_OTHER, 1);
    end
    idle(4);
    check("cnt_wrap", 32'(tok_cnt), 32'd0);
    check("hold_valid_low", 32'(tok_valid), 32'd0);
    check("hold_kind", 32'(tok_kind), 32'(TOK_OTHER));
    check("hold_len", 32'(tok_len), 32'd1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
